// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode values, instruction field
// positions and the control FSM state type.
package decode_stage_pkg;

    localparam logic [3:0] OP_BRANCH = 4'b1011;
    localparam logic [3:0] OP_JUMP   = 4'b1100;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    // Low bit of each field inside the 16-bit instruction word
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RD_LSB     = 8;
    localparam int unsigned RS1_LSB    = 4;
    localparam int unsigned RS2_LSB    = 0;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_LSB = 4;

    typedef enum logic [1:0] {
        StRun,
        StHold,
        StHalt
    } state_e;

    // Opcodes that carry an absolute target in [11:4]
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_BRANCH) || (op == OP_JUMP);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/execute-facing signal bundle of the decode stage.
// slave: the decode stage itself; master: whatever drives it (fetch/execute).
interface decode_stage_if;
    logic [15:0] instruction;
    logic [7:0]  PC_in;
    logic        valid_in;
    logic        ex_ready;
    logic        flush;
    logic        resolve_valid;
    logic [7:0]  resolve_pc;
    logic        resolve_taken;

    logic        stall;
    logic        jump;
    logic        predict_taken;
    logic [7:0]  branch_target;
    logic        halt;

    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  imm;
    logic [7:0]  PC_out;
    logic        valid_out;
    logic        pred_out;

    modport slave (
        input  instruction, PC_in, valid_in, ex_ready, flush,
               resolve_valid, resolve_pc, resolve_taken,
        output stall, jump, predict_taken, branch_target, halt,
               opcode, rd, rs1, rs2, imm, PC_out, valid_out, pred_out
    );

    modport master (
        output instruction, PC_in, valid_in, ex_ready, flush,
               resolve_valid, resolve_pc, resolve_taken,
        input  stall, jump, predict_taken, branch_target, halt,
               opcode, rd, rs1, rs2, imm, PC_out, valid_out, pred_out
    );
endinterface

// File: rtl/branch_predictor.sv
// Table of 2-bit saturating counters, indexed by PC low bits.
// Lookup reads the registered table, so a same-cycle update to the same entry
// is not visible until the following cycle.
module branch_predictor #(
    parameter int unsigned Depth = 16,
    parameter int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IdxW-1:0] lookup_idx_i,
    output logic            lookup_taken_o,
    input  logic            upd_valid_i,
    input  logic [IdxW-1:0] upd_idx_i,
    input  logic            upd_taken_i
);

    logic [1:0] ctr_q [Depth];
    logic [1:0] upd_cur;
    logic [1:0] upd_nxt;

    // Saturating next value for the entry being resolved
    always_comb begin
        upd_cur = ctr_q[upd_idx_i];
        upd_nxt = upd_cur;
        if (upd_taken_i) begin
            if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'd1;
        end
    end

    // Counter storage; reset to weakly not-taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) ctr_q[i] <= 2'b01;
        end else if (upd_valid_i) begin
            ctr_q[upd_idx_i] <= upd_nxt;
        end
    end

    assign lookup_taken_o = ctr_q[lookup_idx_i][1];

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage: registers decoded fields toward execute, tells
// fetch about jumps/branch targets, and stops on a halt word until flushed.
// Optional branch prediction is enabled with the macro BRANCH_PREDICT_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);

    state_e     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] rd_q, rd_d;
    logic [3:0] rs1_q, rs1_d;
    logic [3:0] rs2_q, rs2_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] pc_q, pc_d;
    logic       valid_q, valid_d;
    logic       pred_q, pred_d;
    logic       halt_q, halt_d;

    logic [3:0] in_op;
    logic       in_run;
    logic       ctr_taken;
    logic       pred_hit;

    assign in_op  = bus.instruction[OPCODE_LSB +: 4];
    assign in_run = (state_q == StRun);

`ifdef BRANCH_PREDICT_EN
    localparam int unsigned BhtIdxW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    branch_predictor #(
        .Depth (BHT_DEPTH),
        .IdxW  (BhtIdxW)
    ) u_bp (
        .clk_i          (clk),
        .rst_i          (reset),
        .lookup_idx_i   (bus.PC_in[BhtIdxW-1:0]),
        .lookup_taken_o (ctr_taken),
        .upd_valid_i    (bus.resolve_valid),
        .upd_idx_i      (bus.resolve_pc[BhtIdxW-1:0]),
        .upd_taken_i    (bus.resolve_taken)
    );
`else
    logic unused_resolve;
    assign ctr_taken      = 1'b0;
    assign unused_resolve = ^{bus.resolve_valid, bus.resolve_pc, bus.resolve_taken,
                              BHT_DEPTH[0]};
`endif

    // Counter verdict for the incoming word, independent of FSM state so that
    // a word accepted out of HOLD still carries its prediction
    assign pred_hit = bus.valid_in && (in_op == OP_BRANCH) && ctr_taken;

    // Fetch-side combinational outputs
    always_comb begin
        bus.jump          = bus.valid_in && in_run && (in_op == OP_JUMP);
        bus.predict_taken = pred_hit && in_run;
        bus.branch_target = (bus.valid_in && is_ctrl_op(in_op)) ?
                            bus.instruction[TARGET_LSB +: 8] : 8'h00;
        bus.stall         = !in_run || (valid_q && !bus.ex_ready);
    end

    // Next-state and output-register update; flush beats everything
    always_comb begin
        logic accept;
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        pred_d   = pred_q;
        halt_d   = halt_q;
        accept   = 1'b0;

        if (bus.flush) begin
            valid_d = 1'b0;
            halt_d  = 1'b0;
            state_d = StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (valid_q && !bus.ex_ready) state_d = StHold;
                    else                          accept  = 1'b1;
                end
                StHold: begin
                    if (bus.ex_ready) begin
                        state_d = StRun;
                        accept  = 1'b1;
                    end
                end
                StHalt: begin
                    // Let execute take the halt word once, then go quiet
                    if (valid_q && bus.ex_ready) valid_d = 1'b0;
                end
                default: state_d = StRun;
            endcase
        end

        if (accept) begin
            if (bus.valid_in) begin
                opcode_d = in_op;
                rd_d     = bus.instruction[RD_LSB +: 4];
                rs1_d    = bus.instruction[RS1_LSB +: 4];
                rs2_d    = bus.instruction[RS2_LSB +: 4];
                imm_d    = bus.instruction[IMM_LSB +: 8];
                pc_d     = bus.PC_in;
                valid_d  = 1'b1;
                pred_d   = pred_hit;
                if (in_op == OP_HALT) begin
                    halt_d  = 1'b1;
                    state_d = StHalt;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            pred_q   <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            pred_q   <= pred_d;
            halt_q   <= halt_d;
        end
    end

    assign bus.opcode    = opcode_q;
    assign bus.rd        = rd_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.imm       = imm_q;
    assign bus.PC_out    = pc_q;
    assign bus.valid_out = valid_q;
    assign bus.pred_out  = pred_q;
    assign bus.halt      = halt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: transaction-level model compared every cycle plus
// hand-computed literal expectations. Honours BRANCH_PREDICT_EN if defined.
module tb_decode_stage;

`ifdef BRANCH_PREDICT_EN
    localparam logic Bpe = 1'b1;
`else
    localparam logic Bpe = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage #(.BHT_DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- model ----------------
    // Holds the word execute currently sees, whether it is held back, whether
    // the stage has stopped on a halt, and the predictor counters as integers.
    bit          m_live = 1'b0;
    logic        m_valid, m_hold, m_halt, m_pred;
    logic [15:0] m_word;
    logic [7:0]  m_pc;
    int          ctr [16];

    always @(posedge clk) begin : model
        bit pred_now;
        int ri;
        if (reset) begin
            m_valid = 0; m_hold = 0; m_halt = 0; m_pred = 0;
            m_word  = '0; m_pc = '0;
            for (int i = 0; i < 16; i++) ctr[i] = 1;
            m_live = 1'b1;
        end else begin
            pred_now = Bpe && bus.valid_in && (bus.instruction[15:12] == 4'hB)
                       && (ctr[bus.PC_in[3:0]] >= 2);
            if (bus.flush) begin
                m_valid = 0; m_hold = 0; m_halt = 0;
            end else if (!m_halt && (!m_valid || bus.ex_ready)) begin
                // A new word is taken whenever execute is not refusing the current one
                m_hold = 0;
                if (bus.valid_in) begin
                    m_word  = bus.instruction;
                    m_pc    = bus.PC_in;
                    m_valid = 1;
                    m_pred  = pred_now;
                    if (bus.instruction[15:12] == 4'hF) m_halt = 1;
                end else begin
                    m_valid = 0;
                end
            end else if (m_halt) begin
                if (m_valid && bus.ex_ready) m_valid = 0;
            end else begin
                m_hold = 1;
            end
            if (Bpe && bus.resolve_valid) begin
                ri = int'(bus.resolve_pc[3:0]);
                if (bus.resolve_taken) ctr[ri] = (ctr[ri] < 3) ? ctr[ri] + 1 : 3;
                else                   ctr[ri] = (ctr[ri] > 0) ? ctr[ri] - 1 : 0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin : compare
        logic [3:0] op;
        logic       run_now;
        logic       e_jump, e_pt, e_stall;
        logic [7:0] e_bt;
        if (m_live) begin
            op      = bus.instruction[15:12];
            run_now = !m_hold && !m_halt;
            e_jump  = bus.valid_in && run_now && (op == 4'hC);
            e_pt    = Bpe && bus.valid_in && run_now && (op == 4'hB)
                      && (ctr[bus.PC_in[3:0]] >= 2);
            e_bt    = (bus.valid_in && (op == 4'hB || op == 4'hC)) ?
                      bus.instruction[11:4] : 8'h00;
            e_stall = m_hold || m_halt || (m_valid && !bus.ex_ready);
            check("m.valid_out", bus.valid_out, m_valid);
            check("m.halt", bus.halt, m_halt);
            check("m.stall", bus.stall, e_stall);
            check("m.jump", bus.jump, e_jump);
            check("m.predict_taken", bus.predict_taken, e_pt);
            check("m.branch_target", bus.branch_target, e_bt);
            check("m.pred_out", bus.pred_out, m_pred);
            check("m.opcode", bus.opcode, m_word[15:12]);
            check("m.rd", bus.rd, m_word[11:8]);
            check("m.rs1", bus.rs1, m_word[7:4]);
            check("m.rs2", bus.rs2, m_word[3:0]);
            check("m.imm", bus.imm, m_word[7:0]);
            check("m.PC_out", bus.PC_out, m_pc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] w, input logic [7:0] pc, input logic vin,
                         input logic exr, input logic fl);
        bus.instruction = w;
        bus.PC_in       = pc;
        bus.valid_in    = vin;
        bus.ex_ready    = exr;
        bus.flush       = fl;
    endtask

    task automatic resolve(input logic v, input logic [7:0] pc, input logic t);
        bus.resolve_valid = v;
        bus.resolve_pc    = pc;
        bus.resolve_taken = t;
    endtask

    typedef struct packed {
        logic [15:0] w;
        logic [7:0]  pc;
        logic        vin;
        logic        exr;
        logic        fl;
        logic        rv;
        logic [7:0]  rpc;
        logic        rt;
    } vec_t;

    vec_t vecs [10] = '{
        '{16'hB120, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1},
        '{16'hB120, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1},
        '{16'hB120, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'hC880, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 8'h17, 1'b0},
        '{16'hC880, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'hF000, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'hB120, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0},
        '{16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0}
    };

    initial begin
        drive(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        resolve(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst valid_out", bus.valid_out, 1'b0);
        check("rst opcode", bus.opcode, 4'h0);
        check("rst PC_out", bus.PC_out, 8'h00);
        check("rst halt", bus.halt, 1'b0);
        check("rst stall", bus.stall, 1'b0);

        // Basic decode, one-cycle latency
        drive(16'h1234, 8'h05, 1'b1, 1'b1, 1'b0);
        tick();
        check("dec opcode", bus.opcode, 4'h1);
        check("dec rd", bus.rd, 4'h2);
        check("dec rs1", bus.rs1, 4'h3);
        check("dec rs2", bus.rs2, 4'h4);
        check("dec imm", bus.imm, 8'h34);
        check("dec PC_out", bus.PC_out, 8'h05);
        check("dec valid_out", bus.valid_out, 1'b1);

        // Back-pressure: hold for three cycles, then release
        drive(16'h5678, 8'h06, 1'b1, 1'b0, 1'b0);
        #1 check("refuse stall", bus.stall, 1'b1);
        tick();
        repeat (3) begin
            check("hold stall", bus.stall, 1'b1);
            check("hold opcode", bus.opcode, 4'h1);
            check("hold PC_out", bus.PC_out, 8'h05);
            tick();
        end
        drive(16'h5678, 8'h06, 1'b1, 1'b1, 1'b0);
        #1 check("hold release stall", bus.stall, 1'b1);
        tick();
        check("release opcode", bus.opcode, 4'h5);
        check("release PC_out", bus.PC_out, 8'h06);
        check("release stall", bus.stall, 1'b0);

        // Jump
        drive(16'hC400, 8'h10, 1'b1, 1'b1, 1'b0);
        #1;
        check("jump", bus.jump, 1'b1);
        check("jump target", bus.branch_target, 8'h40);
        check("jump pt", bus.predict_taken, 1'b0);
        tick();

        // Branch, cold predictor
        drive(16'hB2A0, 8'h03, 1'b1, 1'b1, 1'b0);
        #1;
        check("br target", bus.branch_target, 8'h2A);
        check("br pt cold", bus.predict_taken, 1'b0);
        check("br jump", bus.jump, 1'b0);
        tick();
        check("br pred_out cold", bus.pred_out, 1'b0);

        // Fetch outputs quiet without valid; train PC 03 taken twice
        drive(16'hB2A0, 8'h03, 1'b0, 1'b1, 1'b0);
        #1 check("novalid target", bus.branch_target, 8'h00);
        resolve(1'b1, 8'h03, 1'b1);
        tick();
        tick();
        resolve(1'b0, 8'h00, 1'b0);
        drive(16'hB2A0, 8'h03, 1'b1, 1'b1, 1'b0);
        #1 check("br pt trained", bus.predict_taken, Bpe);
        tick();
        check("br pred_out trained", bus.pred_out, Bpe);

        // Same-cycle resolve reads the pre-update counter (3 -> 2 -> 1)
        resolve(1'b1, 8'h03, 1'b0);
        #1 check("war lookup", bus.predict_taken, Bpe);
        tick();
        tick();
        resolve(1'b0, 8'h00, 1'b0);
        #1 check("after untrain pt", bus.predict_taken, 1'b0);
        tick();

        // Halt and flush out of it
        drive(16'hF000, 8'h20, 1'b1, 1'b1, 1'b0);
        tick();
        check("halt", bus.halt, 1'b1);
        check("halt stall", bus.stall, 1'b1);
        check("halt valid_out", bus.valid_out, 1'b1);
        check("halt opcode", bus.opcode, 4'hF);
        drive(16'h1234, 8'h21, 1'b1, 1'b1, 1'b0);
        tick();
        check("halt drained valid", bus.valid_out, 1'b0);
        check("halt ignores word", bus.PC_out, 8'h20);
        tick();
        check("halt persists", bus.halt, 1'b1);
        check("halt stall persists", bus.stall, 1'b1);
        drive(16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        drive(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush halt", bus.halt, 1'b0);
        check("flush halt valid", bus.valid_out, 1'b0);
        check("flush halt stall", bus.stall, 1'b0);

        // Flush together with ex_ready=0 while holding
        drive(16'h2345, 8'h30, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h3456, 8'h31, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold2 stall", bus.stall, 1'b1);
        drive(16'h3456, 8'h31, 1'b1, 1'b0, 1'b1);
        tick();
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        check("flush hold valid", bus.valid_out, 1'b0);
        check("flush hold stall", bus.stall, 1'b0);

        // Flush beats an incoming valid word
        drive(16'h7777, 8'h40, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush beats accept", bus.valid_out, 1'b0);

        // Reset in the middle of HOLD
        drive(16'h4444, 8'h50, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h5555, 8'h51, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst hold valid", bus.valid_out, 1'b0);
        check("rst hold opcode", bus.opcode, 4'h0);
        check("rst hold stall", bus.stall, 1'b0);
        drive(16'hB2A0, 8'h03, 1'b1, 1'b1, 1'b0);
        #1 check("rst counters", bus.predict_taken, 1'b0);
        tick();

        // Mixed vectors, checked by the model only
        foreach (vecs[i]) begin
            drive(vecs[i].w, vecs[i].pc, vecs[i].vin, vecs[i].exr, vecs[i].fl);
            resolve(vecs[i].rv, vecs[i].rpc, vecs[i].rt);
            tick();
        end
        resolve(1'b0, 8'h00, 1'b0);
        drive(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 16, number of 2-bit predictor counters (power of two, indexed by PC low bits).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: instruction  in  16  fetched word; PC_in  in  8  its address; valid_in  in  1  word valid.
REQ-004 SHALL have ports: ex_ready  in  1  execute accepts; flush  in  1  execute redirect, kill in-flight.
REQ-005 SHALL have ports: resolve_valid  in  1  branch resolved; resolve_pc  in  8  its PC; resolve_taken  in  1  actual outcome.
REQ-006 SHALL have ports to fetch: stall  out  1; jump  out  1; predict_taken  out  1; branch_target  out  8; halt  out  1.
REQ-007 SHALL have ports to execute: opcode  out  4; rd  out  4; rs1  out  4; rs2  out  4; imm  out  8; PC_out  out  8; valid_out  out  1; pred_out  out  1 (prediction carried with the branch).

Function
REQ-008 Opcode encoding SHALL be: 4'b1011 conditional branch, 4'b1100 jump, 4'b1111 halt, all others ALU/memory.
REQ-009 Fields SHALL be: opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0], imm [7:0]; branch/jump target [11:4], absolute.
REQ-010 States SHALL be RUN, HOLD, HALT; reset enters RUN.
REQ-011 RUN: valid_in && !flush SHALL register decoded fields, PC_out <= PC_in, valid_out <= 1 at the next edge (latency 1 cycle).
REQ-012 RUN with valid_out=1 and ex_ready=0 SHALL go to HOLD; output registers frozen; incoming word not accepted.
REQ-013 HOLD SHALL assert stall and keep all outputs stable; ex_ready=1 returns to RUN, accepting the incoming word that edge.
REQ-014 stall SHALL be combinational: (state==HOLD) || (state==HALT) || (valid_out && !ex_ready).
REQ-015 jump SHALL be 1 when valid_in, state RUN, opcode 1100; branch_target = instruction[11:4] for 1011/1100, else 8'h00.
REQ-016 predict_taken SHALL be 1 when valid_in, state RUN, opcode 1011, and counter[PC_in index] MSB is 1.
REQ-017 Accepting a valid halt word SHALL register it, assert halt, enter HALT; HALT keeps stall=1, valid_out drops after one handshake.
REQ-018 flush SHALL clear valid_out at the next edge, drop any held word, leave HOLD or HALT for RUN, and deassert halt; flush overrides every other event.
REQ-019 resolve_valid SHALL update counter[resolve_pc index]: taken saturating increment to 3, not-taken saturating decrement to 0.
REQ-020 Resolution and lookup on the same index in one cycle SHALL return the pre-update counter (write-after-read).
REQ-021 valid_in=0 in RUN with ex_ready=1 SHALL clear valid_out; field registers may hold stale values.
REQ-022 Outputs to fetch SHALL be 0 (except stall per REQ-014) when valid_in=0.

Reset
REQ-023 reset SHALL set state RUN, valid_out 0, halt 0, all field registers and PC_out 0, pred_out 0.
REQ-024 reset SHALL set every counter to 2'b01 (weakly not-taken); reset mid-HOLD/HALT discards contents.

Configuration
REQ-025 Macro BRANCH_PREDICT_EN defined: counter table present, behaviour per REQ-016/019/020.
REQ-026 BRANCH_PREDICT_EN undefined: no table, predict_taken and pred_out constant 0, resolve inputs ignored.

Structure
REQ-027 Shared package SHALL hold opcode constants (OP_BRANCH, OP_JUMP, OP_HALT), field bit positions, and state enum.
REQ-028 Predictor SHALL be sub-module branch_predictor (lookup port, update port, sync reset); instantiated only under BRANCH_PREDICT_EN.

Verification
REQ-029 Reset, then instruction 16'h1234, PC_in 8'h05, valid_in 1, ex_ready 1 -> next cycle opcode 1, rd 2, rs1 3, rs2 4, PC_out 05, valid_out 1.
REQ-030 Word held with ex_ready 0 for 3 cycles -> stall 1 throughout, outputs unchanged; ex_ready 1 -> next word registered next edge.
REQ-031 Branch 16'hB2A0 at PC 8'h03 after reset -> branch_target 8'h2A, predict_taken 0; two taken resolves at PC 03 -> predict_taken 1.
REQ-032 Jump 16'hC400 -> jump 1, branch_target 8'h40 the same cycle, predict_taken 0.
REQ-033 Halt 16'hF000 accepted -> halt 1, stall 1 persistently; flush -> valid_out 0, halt 0, RUN next edge.
REQ-034 flush and ex_ready 0 in the same cycle during HOLD -> valid_out 0, RUN, stall 0 next cycle.
